// File: rtl/credit_fifo_sender_pkg.sv
// -----------------------------------------------------------------------------
// credit_fifo_sender_pkg
//   Shared definitions for the credit-based FIFO sender:
//     - log2c()   : ceil(log2(n)) with a minimum of 1, used to derive the
//                   credit counter width CWIDTH = log2c(CREDITS + 1)
//     - cred_op_e : per-cycle credit counter update (HOLD / INC / DEC)
//   No ports (package).
// -----------------------------------------------------------------------------
package credit_fifo_sender_pkg;

   // Bits needed to hold values 0 .. n-1 (never less than 1).
   function automatic int unsigned log2c(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) begin
         w = w + 1;
      end
      return w;
   endfunction

   typedef enum logic [1:0] {
      CRED_HOLD,
      CRED_INC,
      CRED_DEC
   } cred_op_e;

endpackage

// File: rtl/credit_fifo_sender_if.sv
// -----------------------------------------------------------------------------
// credit_fifo_sender_if
//   Handshake bundle around the credit sender.
//     iValid / iReady / iDat : upstream valid/ready stream
//     oValid / oDat          : write strobe + payload to the downstream FIFO
//     crdRet                 : one-cycle pulse per downstream FIFO pop
//   modport master : the sender itself (drives iReady, oValid, oDat)
//   modport slave  : the surrounding logic (drives iValid, iDat, crdRet)
// -----------------------------------------------------------------------------
interface credit_fifo_sender_if #(
   parameter int unsigned DATA = 1
);
   logic            iValid;
   logic            iReady;
   logic [DATA-1:0] iDat;
   logic            oValid;
   logic [DATA-1:0] oDat;
   logic            crdRet;

   modport master (
      input  iValid,
      input  iDat,
      input  crdRet,
      output iReady,
      output oValid,
      output oDat
   );

   modport slave (
      output iValid,
      output iDat,
      output crdRet,
      input  iReady,
      input  oValid,
      input  oDat
   );
endinterface

// File: rtl/credit_fifo_sender_delay_line.sv
// -----------------------------------------------------------------------------
// credit_delay_line
//   Fixed-latency, non-stallable valid+data shift register of LATENCY stages.
//   Every cycle stage k moves to stage k+1; out_* is the last stage.
//   Only the valid bits are reset/flushed; a data stage loads only when the
//   valid entering it is 1.
//   Ports:
//     clk       : clock
//     rstN      : synchronous active-low reset (clears valid bits)
//     clear     : synchronous flush, same effect as rstN low
//     in_vld_i  : valid entering stage 0
//     in_dat_i  : data entering stage 0
//     out_vld_o : valid of last stage
//     out_dat_o : data of last stage (don't-care while out_vld_o = 0)
// -----------------------------------------------------------------------------
module credit_delay_line #(
   parameter int unsigned DATA    = 1,
   parameter int unsigned LATENCY = 1
) (
   input  logic            clk,
   input  logic            rstN,
   input  logic            clear,
   input  logic            in_vld_i,
   input  logic [DATA-1:0] in_dat_i,
   output logic            out_vld_o,
   output logic [DATA-1:0] out_dat_o
);

   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] vld_d;
   logic [DATA-1:0]    dat_q [LATENCY];

   always_comb begin
      vld_d    = vld_q;
      vld_d[0] = in_vld_i;
      for (int unsigned k = 1; k < LATENCY; k++) begin
         vld_d[k] = vld_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN || clear) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // Data flops are unreset and gated by the incoming valid to save toggling.
   always_ff @(posedge clk) begin
      if (in_vld_i) begin
         dat_q[0] <= in_dat_i;
      end
      for (int unsigned k = 1; k < LATENCY; k++) begin
         if (vld_q[k-1]) begin
            dat_q[k] <= dat_q[k-1];
         end
      end
   end

   assign out_vld_o = vld_q[LATENCY-1];
   assign out_dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/credit_fifo_sender.sv
// -----------------------------------------------------------------------------
// credit_fifo_sender
//   Transmit side of a credit-controlled link into a downstream FIFO of
//   CREDITS entries. Items are issued into a fixed LATENCY delay line whose
//   output writes the FIFO with no backpressure; one credit is consumed per
//   issue and returned per FIFO pop, so the FIFO can never overflow.
//   Ports:
//     clk     : clock
//     rstN    : synchronous active-low reset (priority over clear)
//     clear   : synchronous flush, same effect as reset
//     bus     : credit_fifo_sender_if.master (iValid/iReady/iDat,
//               oValid/oDat, crdRet)
//     credits : currently available credits
//     idle    : nothing in flight or buffered (credits == CREDITS)
//     err     : sticky error, only with `CREDIT_SENDER_ERRCHK_EN defined
//               (credit overflow or >2^16-cycle starvation)
//   Optional feature macro: CREDIT_SENDER_ERRCHK_EN
// -----------------------------------------------------------------------------
module credit_fifo_sender
   import credit_fifo_sender_pkg::*;
#(
   parameter  int unsigned DATA    = 1,
   parameter  int unsigned LATENCY = 1,
   parameter  int unsigned CREDITS = 1,
   localparam int unsigned CWIDTH  = log2c(CREDITS + 1)
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 clear,
   credit_fifo_sender_if.master bus,
   output logic [CWIDTH-1:0]    credits,
   output logic                 idle
`ifdef CREDIT_SENDER_ERRCHK_EN
   ,
   output logic                 err
`endif
);

   localparam logic [CWIDTH-1:0] CRED_MAX = CWIDTH'(CREDITS);

   logic              flush;
   logic              ready;
   logic              issue;
   logic              out_vld;
   logic [DATA-1:0]   out_dat;
   cred_op_e          cred_op;
   logic [CWIDTH-1:0] credits_q;
   logic [CWIDTH-1:0] credits_d;

   assign flush = !rstN || clear;

   // Ready comes only from the registered count: no comb path from crdRet.
   assign ready = (credits_q != '0);
   assign issue = bus.iValid && ready;

   always_comb begin
      cred_op = CRED_HOLD;
      if (issue && !bus.crdRet) begin
         cred_op = CRED_DEC;
      end else if (!issue && bus.crdRet) begin
         cred_op = CRED_INC;
      end
   end

   // An extra return at full count is illegal; saturate instead of wrapping.
   always_comb begin
      credits_d = credits_q;
      unique case (cred_op)
         CRED_DEC: credits_d = credits_q - CWIDTH'(1);
         CRED_INC: credits_d = (credits_q == CRED_MAX) ? credits_q
                                                       : credits_q + CWIDTH'(1);
         default:  credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         credits_q <= CRED_MAX;
      end else begin
         credits_q <= credits_d;
      end
   end

   credit_delay_line #(
      .DATA    (DATA),
      .LATENCY (LATENCY)
   ) u_dly (
      .clk       (clk),
      .rstN      (rstN),
      .clear     (clear),
      .in_vld_i  (issue),
      .in_dat_i  (bus.iDat),
      .out_vld_o (out_vld),
      .out_dat_o (out_dat)
   );

   assign bus.iReady = ready;
   assign bus.oValid = out_vld;
   assign bus.oDat   = out_dat;
   assign credits    = credits_q;
   assign idle       = (credits_q == CRED_MAX);

`ifdef CREDIT_SENDER_ERRCHK_EN
   localparam int unsigned IWIDTH = log2c(LATENCY + 1);

   logic              stall;
   logic              overflow;
   logic [16:0]       wdog_q;
   logic [16:0]       wdog_d;
   logic              err_q;
   logic              err_d;
   logic [IWIDTH-1:0] inflight_q;
   logic [IWIDTH-1:0] inflight_d;

   assign stall    = bus.iValid && !ready;
   assign overflow = bus.crdRet && (credits_q == CRED_MAX) && !issue;

   // wdog counts consecutive starved cycles and parks at 2^16; a further
   // starved cycle then means more than 2^16 in a row.
   always_comb begin
      wdog_d = '0;
      if (stall) begin
         wdog_d = wdog_q[16] ? wdog_q : wdog_q + 17'd1;
      end
      err_d      = err_q || overflow || (stall && wdog_q[16]);
      inflight_d = inflight_q + IWIDTH'(issue) - IWIDTH'(out_vld);
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wdog_q     <= '0;
         err_q      <= 1'b0;
         inflight_q <= '0;
      end else begin
         wdog_q     <= wdog_d;
         err_q      <= err_d;
         inflight_q <= inflight_d;
      end
   end

   assign err = err_q;

   // Visible part of the credit invariant: downstream occupancy is not seen
   // here, so credits plus in-flight items may never exceed CREDITS.
   a_credit_invariant: assert property (
      @(posedge clk) disable iff (!rstN || clear)
      (32'(credits_q) + 32'(inflight_q)) <= 32'(CREDITS)
   );
`endif

endmodule

// File: tb/tb_credit_fifo_sender.sv
// -----------------------------------------------------------------------------
// tb_credit_fifo_sender
//   Bench for credit_fifo_sender with DATA=8, LATENCY=3, CREDITS=4.
//   A model process tracks credits with plain arithmetic, keeps the in-flight
//   items and a downstream FIFO as queues, and pushes each issued item with its
//   due cycle into a scoreboard; a separate monitor pops and compares whenever
//   the DUT presents oValid.
// -----------------------------------------------------------------------------
module tb_credit_fifo_sender;

   localparam int unsigned DATA    = 8;
   localparam int unsigned LATENCY = 3;
   localparam int unsigned CREDITS = 4;
   localparam int unsigned CW      = $clog2(CREDITS + 1);

   typedef struct {
      logic [DATA-1:0] d;
      int              due;
   } item_t;

   logic          clk = 1'b0;
   logic          rstN;
   logic          clear;
   logic [CW-1:0] credits;
   logic          idle;
`ifdef CREDIT_SENDER_ERRCHK_EN
   logic          err;
`endif

   credit_fifo_sender_if #(.DATA(DATA)) bus ();

   credit_fifo_sender #(
      .DATA    (DATA),
      .LATENCY (LATENCY),
      .CREDITS (CREDITS)
   ) dut (
      .clk     (clk),
      .rstN    (rstN),
      .clear   (clear),
      .bus     (bus),
      .credits (credits),
      .idle    (idle)
`ifdef CREDIT_SENDER_ERRCHK_EN
      ,
      .err     (err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   item_t           exp_q[$];
   int              inflight_q[$];
   logic [DATA-1:0] fifo_q[$];
   int              cred_m   = 0;
   bit              model_ok = 1'b0;
   bit              err_m    = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: credits, in-flight items, downstream FIFO.
   always @(negedge clk) begin
      bit issue;
      if (model_ok && cyc >= 1) begin
         chk("credits", 64'(credits), 64'(cred_m));
         chk("iReady", 64'(bus.iReady), 64'(cred_m != 0));
         chk("idle", 64'(idle), 64'(cred_m == CREDITS));
         chk("invariant", 64'(int'(credits) + inflight_q.size() + fifo_q.size()), 64'(CREDITS));
`ifdef CREDIT_SENDER_ERRCHK_EN
         chk("err", 64'(err), 64'(err_m));
`endif
         if (bus.oValid === 1'b1) begin
            chk("fifo_write_when_full", 64'(fifo_q.size() < CREDITS), 64'(1));
         end
      end
      if (!rstN || clear) begin
         cred_m = CREDITS;
         inflight_q.delete();
         fifo_q.delete();
         err_m    = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         issue = bus.iValid && (cred_m != 0);
         if (bus.crdRet && cred_m == CREDITS && !issue) err_m = 1'b1;
         if (bus.crdRet && fifo_q.size() > 0) void'(fifo_q.pop_front());
         if (bus.oValid === 1'b1) fifo_q.push_back(bus.oDat);
         if (inflight_q.size() > 0 && inflight_q[0] == cyc) void'(inflight_q.pop_front());
         if (issue) begin
            inflight_q.push_back(cyc + LATENCY);
            exp_q.push_back('{d: bus.iDat, due: cyc + LATENCY});
         end
         cred_m = cred_m - int'(issue) + int'(bus.crdRet);
         if (cred_m > CREDITS) cred_m = CREDITS;
      end
   end

   // Output monitor: pops the scoreboard whenever the DUT writes the FIFO.
   always @(negedge clk) begin
      item_t e;
      if (cyc >= 1) begin
         if (bus.oValid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_oValid", 64'(bus.oValid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("oDat", 64'(bus.oDat), 64'(e.d));
               chk("oValid_cycle", 64'(cyc), 64'(e.due));
            end
         end else begin
            chk("oValid_idle", 64'(bus.oValid), 64'(0));
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               chk("oValid_missing", 64'(bus.oValid), 64'(1));
               void'(exp_q.pop_front());
            end
         end
      end
      if (!rstN || clear) exp_q.delete();
   end

   task automatic step(input bit v, input logic [DATA-1:0] d, input bit r, input bit c);
      bus.iValid = v;
      bus.iDat   = d;
      bus.crdRet = r;
      clear      = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit drained;
      rstN       = 1'b0;
      clear      = 1'b0;
      bus.iValid = 1'b0;
      bus.iDat   = '0;
      bus.crdRet = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;

      // iValid held: exactly CREDITS issues, then blocked at credits = 0.
      for (int i = 0; i < 8; i++) step(1'b1, DATA'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);

      // Two pops bring credits to 2, then issue and return together.
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 8'hA0, 1'b1, 1'b0);
      step(1'b1, 8'hA1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);

      // Exhaust credits, single return at zero, re-issue back to zero.
      for (int i = 0; i < 4; i++) step(1'b1, DATA'(8'hB0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 8'hC0, 1'b0, 1'b0);
      step(1'b1, 8'hC1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);

      // Clear with three items in flight.
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, DATA'(8'hD0 + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);

      // Spurious return at full credits, then clear.
      step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);

      // Random traffic; returns only for entries really in the FIFO.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 70, DATA'($urandom),
              (fifo_q.size() > 0) && ($urandom_range(0, 3) != 0), 1'b0);
      end

      // Drain everything back to idle.
      drained = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (fifo_q.size() == 0 && inflight_q.size() == 0) begin
            drained = 1'b1;
            break;
         end
         step(1'b0, '0, fifo_q.size() > 0, 1'b0);
      end
      chk("drain_done", 64'(drained), 64'(1));
      step(1'b0, '0, 1'b0, 1'b0);
      chk("idle_final", 64'(idle), 64'(1));
      chk("credits_final", 64'(credits), 64'(CREDITS));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
